// File: rtl/arith_pkg.sv
// Shared constants for the arithmetic command sequencer: opcodes, FSM
// encoding and the default operand width.
package arith_pkg;

   localparam int DEF_WIDTH = 8;

   // Datapath opcodes
   localparam logic [1:0] ADD = 2'b00;
   localparam logic [1:0] SUB = 2'b01;
   localparam logic [1:0] MUL = 2'b10;
   localparam logic [1:0] DIV = 2'b11;

   // Sequencer FSM encoding
   typedef logic [2:0] state_t;
   localparam state_t ST_IDLE    = 3'd0;
   localparam state_t ST_ISSUE   = 3'd1;
   localparam state_t ST_WAIT    = 3'd2;
   localparam state_t ST_CAPTURE = 3'd3;
   localparam state_t ST_RESP    = 3'd4;

endpackage

// File: rtl/arith_cmd_sequencer_if.sv
// Request, controller and response signals of the command sequencer.
// slave  = the sequencer itself, master = the surrounding environment.
interface arith_cmd_sequencer_if #(
   parameter int WIDTH = arith_pkg::DEF_WIDTH
);
   logic               req_valid;
   logic               req_ready;
   logic [WIDTH-1:0]   req_a;
   logic [WIDTH-1:0]   req_b;
   logic [1:0]         req_op;
   logic               go;
   logic [WIDTH-1:0]   op_a;
   logic [WIDTH-1:0]   op_b;
   logic [1:0]         op_code;
   logic               done;
   logic [2*WIDTH-1:0] dp_result;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [2*WIDTH-1:0] rsp_result;
   logic [1:0]         rsp_op;
   logic               rsp_err;
   logic               busy;

   modport slave (
      input  req_valid, req_a, req_b, req_op, done, dp_result, rsp_ready,
      output req_ready, go, op_a, op_b, op_code, rsp_valid, rsp_result,
             rsp_op, rsp_err, busy
   );

   modport master (
      output req_valid, req_a, req_b, req_op, done, dp_result, rsp_ready,
      input  req_ready, go, op_a, op_b, op_code, rsp_valid, rsp_result,
             rsp_op, rsp_err, busy
   );
endinterface

// File: rtl/arith_req_fifo.sv
// Small request FIFO holding {op, a, b}. Pointers wrap naturally because
// DEPTH is a power of two; count is one bit wider to represent "full".
module arith_req_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      push,
   input  logic                      pop,
   input  logic [2+2*WIDTH-1:0]      din,
   output logic [2+2*WIDTH-1:0]      head,
   output logic [$clog2(DEPTH):0]    count,
   output logic                      full,
   output logic                      empty
);
   localparam int EW = 2 + 2*WIDTH;
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [EW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          wr_en, rd_en;

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
   assign wr_en = push & ~full;
   assign rd_en = pop & ~empty;
   assign head  = mem[rd_ptr];

   // Storage needs no reset; only valid entries are ever read.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= din;
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (rd_en) rd_ptr <= rd_ptr + AW'(1);
         case ({wr_en, rd_en})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/arith_cmd_sequencer.sv
// Front-end for the multicycle arithmetic unit: queues requests, issues one
// at a time with a go pulse, waits for done (watchdog-guarded) and returns
// the captured result on a valid/ready response port.
module arith_cmd_sequencer
   import arith_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   arith_cmd_sequencer_if.slave bus
);
   localparam int EW  = 2 + 2*WIDTH;
   localparam int CW  = $clog2(DEPTH) + 1;
   localparam int WDW = $clog2(TIMEOUT);

   state_t          state;
   logic [WDW-1:0]  wd;
   logic [EW-1:0]   head;
   logic [CW-1:0]   fifo_count;
   logic            full, empty, push, pop;

   assign push          = bus.req_valid & ~full;
   assign pop           = (state == ST_IDLE) & ~empty;
   assign bus.req_ready = (fifo_count != CW'(DEPTH));
   assign bus.go        = (state == ST_ISSUE);
   assign bus.busy      = (state != ST_IDLE) | (fifo_count != '0);

   arith_req_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .din   ({bus.req_op, bus.req_a, bus.req_b}),
      .head  (head),
      .count (fifo_count),
      .full  (full),
      .empty (empty)
   );

   // Issue/wait/capture/respond sequencing; operands only move on IDLE->ISSUE
   // so the controller sees them stable when it loads one cycle after go.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= ST_IDLE;
         wd             <= '0;
         bus.op_a       <= '0;
         bus.op_b       <= '0;
         bus.op_code    <= '0;
         bus.rsp_valid  <= 1'b0;
         bus.rsp_result <= '0;
         bus.rsp_op     <= '0;
         bus.rsp_err    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (!empty) begin
                  {bus.op_code, bus.op_a, bus.op_b} <= head;
                  state <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               wd    <= '0;
               state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (bus.done) begin
                  state <= ST_CAPTURE;
               end else if (wd == WDW'(TIMEOUT-1)) begin
                  bus.rsp_result <= '0;
                  bus.rsp_op     <= bus.op_code;
                  bus.rsp_err    <= 1'b1;
                  bus.rsp_valid  <= 1'b1;
                  state          <= ST_RESP;
               end else begin
                  wd <= wd + WDW'(1);
               end
            end
            ST_CAPTURE: begin
               // controller loaded its output register on the done edge
               bus.rsp_result <= bus.dp_result;
               bus.rsp_op     <= bus.op_code;
               bus.rsp_err    <= 1'b0;
               bus.rsp_valid  <= 1'b1;
               state          <= ST_RESP;
            end
            ST_RESP: begin
               if (bus.rsp_ready) begin
                  bus.rsp_valid <= 1'b0;
                  state         <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_arith_cmd_sequencer.sv
// Bench for arith_cmd_sequencer: a transaction-level model (queue of accepted
// requests and their expected responses) checked every cycle, a behavioural
// controller/datapath stand-in, and directed scenarios with literal results.
module tb_arith_cmd_sequencer;
   import arith_pkg::*;

   localparam int W  = 8;
   localparam int D  = 4;
   localparam int TO = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic ctl_done = 1'b0;
   logic spur_done = 1'b0;
   logic done_en = 1'b1;

   arith_cmd_sequencer_if #(.WIDTH(W)) bus();
   assign bus.done = ctl_done | spur_done;

   arith_cmd_sequencer #(.WIDTH(W), .DEPTH(D), .TIMEOUT(TO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]     op;
      logic [W-1:0]   a;
      logic [W-1:0]   b;
      logic [2*W-1:0] res;
      logic           err;
   } exp_t;

   exp_t           exp_q[$];
   logic [2*W-1:0] rsp_log[$];
   int checks = 0, fails = 0, cyc = 0;
   int last_acc = -1, last_go = -1, last_rsp = -1, go_cnt = 0;

   function automatic logic [2*W-1:0] calc(logic [1:0] op, logic [W-1:0] a, logic [W-1:0] b);
      case (op)
         ADD:     return (2*W)'(a) + (2*W)'(b);
         SUB:     return (2*W)'(a) - (2*W)'(b);
         MUL:     return (2*W)'(a) * (2*W)'(b);
         default: return (b == '0) ? '1 : (2*W)'(a / b);
      endcase
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
      end
   endtask

   // Controller/datapath stand-in: done 4 cycles after go, result register
   // loaded on the done edge.
   initial begin
      logic [W-1:0] a, b;
      logic [1:0]   op;
      forever begin
         @(negedge clk);
         if (rst_n && bus.go && done_en) begin
            a = bus.op_a; b = bus.op_b; op = bus.op_code;
            repeat (4) @(posedge clk);
            #1 ctl_done = 1'b1;
            @(posedge clk);
            #1 ctl_done = 1'b0;
            bus.dp_result = calc(op, a, b);
         end
      end
   end

   // Per-cycle comparison against the transaction model.
   initial begin
      logic pv;
      logic inflight;
      exp_t e;
      pv = 1'b0; inflight = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            exp_q.delete();
            pv = 1'b0; inflight = 1'b0;
         end else begin
            // busy whenever an accepted request has not yet been answered
            chk("busy", bus.busy, exp_q.size() != 0);
            if (bus.rsp_valid) begin
               if (exp_q.size() == 0) begin
                  chk("rsp_spurious", bus.rsp_valid, 1'b0);
               end else begin
                  e = exp_q[0];
                  chk("rsp_result", bus.rsp_result, e.res);
                  chk("rsp_op", bus.rsp_op, e.op);
                  chk("rsp_err", bus.rsp_err, e.err);
                  if (bus.rsp_ready) begin
                     rsp_log.push_back(bus.rsp_result);
                     exp_q.pop_front();
                     inflight = 1'b0;
                  end
               end
               if (!pv) last_rsp = cyc;
            end
            pv = bus.rsp_valid;
            if (bus.go) begin
               chk("go_while_inflight", inflight, 1'b0);
               chk("go_has_request", exp_q.size() != 0, 1'b1);
               go_cnt++;
               last_go = cyc;
               inflight = 1'b1;
            end
            if (inflight && exp_q.size() != 0) begin
               chk("op_a", bus.op_a, exp_q[0].a);
               chk("op_b", bus.op_b, exp_q[0].b);
               chk("op_code", bus.op_code, exp_q[0].op);
            end
            if (bus.req_valid && bus.req_ready) begin
               e.op = bus.req_op; e.a = bus.req_a; e.b = bus.req_b;
               e.err = ~done_en;
               e.res = done_en ? calc(bus.req_op, bus.req_a, bus.req_b) : '0;
               exp_q.push_back(e);
               last_acc = cyc;
            end
         end
      end
   end

   // Present one request (called at posedge+1) and hold it until accepted.
   task automatic push_req(logic [1:0] op, logic [W-1:0] a, logic [W-1:0] b);
      int n;
      n = 0;
      bus.req_valid = 1'b1; bus.req_op = op; bus.req_a = a; bus.req_b = b;
      forever begin
         @(negedge clk);
         if (bus.req_ready) break;
         n++;
         if (n > 60) begin
            chk("req_accept_timeout", n, 0);
            break;
         end
      end
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
   endtask

   task automatic wait_rsps(int n);
      int k;
      k = 0;
      while (rsp_log.size() < n) begin
         @(negedge clk);
         k++;
         if (k > 400) begin
            chk("rsp_wait_timeout", rsp_log.size(), n);
            break;
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int base, t, g0;
      logic [2*W-1:0] t3_exp [6];
      t3_exp[0] = 16'd11; t3_exp[1] = 16'd15; t3_exp[2] = 16'd16;
      t3_exp[3] = 16'd5;  t3_exp[4] = 16'd14; t3_exp[5] = 16'd30;
      bus.req_valid = 1'b0; bus.req_a = '0; bus.req_b = '0; bus.req_op = '0;
      bus.rsp_ready = 1'b1; bus.dp_result = '0;

      // Reset state
      #2 rst_n = 1'b0;
      #1;
      chk("rst_go", bus.go, 1'b0);
      chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
      chk("rst_rsp_err", bus.rsp_err, 1'b0);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_rsp_result", bus.rsp_result, 0);
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_req_ready", bus.req_ready, 1'b1);
      @(posedge clk); #1;

      // Single ADD with latency checks
      base = rsp_log.size();
      push_req(ADD, 8'd5, 8'd3);
      t = last_acc;
      wait_rsps(base + 1);
      chk("t1_go_latency", last_go - t, 2);
      chk("t1_rsp_latency", last_rsp - t, 8);
      chk("t1_result", rsp_log[base], 16'd8);

      // Three back-to-back requests
      base = rsp_log.size(); g0 = go_cnt;
      push_req(ADD, 8'd1, 8'd2);
      push_req(SUB, 8'd9, 8'd4);
      push_req(MUL, 8'd3, 8'd7);
      wait_rsps(base + 3);
      chk("t2_r0", rsp_log[base], 16'd3);
      chk("t2_r1", rsp_log[base+1], 16'd5);
      chk("t2_r2", rsp_log[base+2], 16'd21);
      chk("t2_go_count", go_cnt - g0, 3);

      // Backpressure: fill the FIFO, sixth request must wait
      base = rsp_log.size();
      bus.rsp_ready = 1'b0;
      push_req(ADD, 8'd10, 8'd1);
      push_req(SUB, 8'd20, 8'd5);
      push_req(MUL, 8'd4, 8'd4);
      push_req(DIV, 8'd30, 8'd6);
      push_req(ADD, 8'd7, 8'd7);
      @(negedge clk);
      chk("t3_full_ready", bus.req_ready, 1'b0);
      @(posedge clk); #1;
      bus.req_valid = 1'b1; bus.req_op = MUL; bus.req_a = 8'd5; bus.req_b = 8'd6;
      repeat (6) begin
         @(negedge clk);
         chk("t3_hold_ready", bus.req_ready, 1'b0);
      end
      @(posedge clk);
      #1 bus.rsp_ready = 1'b1;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (bus.req_ready) break;
      end
      chk("t3_sixth_accepted", bus.req_ready, 1'b1);
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      wait_rsps(base + 6);
      for (int k = 0; k < 6; k++) chk("t3_order", rsp_log[base+k], t3_exp[k]);

      // Watchdog: TIMEOUT cycles in WAIT_DONE, response registered one edge later
      done_en = 1'b0;
      base = rsp_log.size();
      push_req(ADD, 8'd1, 8'd1);
      wait_rsps(base + 1);
      chk("t4_timeout_latency", last_rsp - last_go, TO + 1);
      chk("t4_timeout_result", rsp_log[base], 0);
      done_en = 1'b1;
      push_req(SUB, 8'd10, 8'd4);
      wait_rsps(base + 2);
      chk("t4_after_timeout", rsp_log[base+1], 16'd6);

      // Reset during WAIT_DONE with two entries queued
      done_en = 1'b0;
      push_req(ADD, 8'd2, 8'd2);
      push_req(ADD, 8'd3, 8'd3);
      push_req(ADD, 8'd4, 8'd4);
      repeat (4) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("t5_go", bus.go, 1'b0);
      chk("t5_rsp_valid", bus.rsp_valid, 1'b0);
      chk("t5_rsp_err", bus.rsp_err, 1'b0);
      chk("t5_busy", bus.busy, 1'b0);
      chk("t5_op_a", bus.op_a, 0);
      chk("t5_op_b", bus.op_b, 0);
      chk("t5_op_code", bus.op_code, 0);
      chk("t5_rsp_result", bus.rsp_result, 0);
      chk("t5_rsp_op", bus.rsp_op, 0);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      done_en = 1'b1;
      base = rsp_log.size();
      repeat (40) @(negedge clk);
      chk("t5_busy_after", bus.busy, 1'b0);
      chk("t5_ready_after", bus.req_ready, 1'b1);
      chk("t5_no_stale", rsp_log.size(), base);
      @(posedge clk); #1;

      // Spurious done while idle
      spur_done = 1'b1;
      @(posedge clk);
      #1 spur_done = 1'b0;
      repeat (5) @(negedge clk);
      chk("t6_busy", bus.busy, 1'b0);
      chk("t6_no_rsp", rsp_log.size(), base);
      @(posedge clk); #1;
      push_req(DIV, 8'd100, 8'd7);
      wait_rsps(base + 1);
      chk("t6_follow_up", rsp_log[base], 16'd14);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
